// File: rtl/timer_pkg.sv
// Shared types, display code constants and preset validation for the countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [3:0] CODE_R = 4'hB;
  localparam logic [3:0] CODE_r = 4'hC;
  localparam logic [3:0] CODE_o = 4'hD;
  localparam logic [3:0] CODE_A = 4'hE;
  localparam logic [3:0] CODE_F = 4'hF;

  // Reads "Rrro" from digit3 down to digit0.
  localparam logic [15:0] ERR_WORD = {CODE_R, CODE_r, CODE_r, CODE_o};

  // MM:SS preset is usable only if every digit is decimal and seconds tens is 0..5.
  function automatic logic bcd_valid(input logic [15:0] p);
    return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) &&
           (p[7:4]   <= 4'd5) && (p[3:0]  <= 4'd9);
  endfunction

endpackage

// File: rtl/display_scan.sv
// Digit multiplexer: walks a 4-digit word onto one code bus with active-low digit enables.
// Code and enable are registered on the same edge so they always belong to the same digit.
module display_scan
  import timer_pkg::*;
#(
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] i_word,
  output logic [3:0]  o_data,
  output logic [3:0]  o_digit_sel
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] r_slot;
  logic [1:0]    r_idx;
  logic          w_wrap;
  logic [1:0]    w_idx_nxt;

  assign w_wrap    = (r_slot == SW'(SCAN_DIV - 1));
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot      <= '0;
      r_idx       <= 2'd0;
      o_data      <= 4'h0;
      o_digit_sel <= 4'b1110;
    end else begin
      r_slot      <= w_wrap ? '0 : r_slot + SW'(1);
      r_idx       <= w_idx_nxt;
      o_data      <= i_word[{w_idx_nxt, 2'b00} +: 4];
      o_digit_sel <= ~(4'b0001 << w_idx_nxt);
    end
  end

endmodule

// File: rtl/countdown_display_driver.sv
// MM:SS countdown timer FSM with BCD decrement, feeding the multiplexed digit display.
// Invalid presets and external faults park the timer in ERROR, which shows a fixed word.
module countdown_display_driver
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        fault,
  input  logic [15:0] preset,
  output logic [3:0]  data,
  output logic [3:0]  digit_sel,
  output logic        running,
  output logic        done,
  output logic        error
);

  localparam int PW = $clog2(TICK_DIV);

  state_t        r_state;
  logic [15:0]   r_count;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic          r_done;
  logic          r_error;

  state_t        w_state_nxt;
  logic [15:0]   w_count_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_done_nxt;
  logic          w_tick;
  logic [15:0]   w_dec;
  logic [15:0]   w_word;

  // Borrow ripples upward: seconds units wrap to 9, seconds tens to 5, minutes units to 9.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = c;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));
  assign w_dec  = bcd_dec(r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_done_nxt  = 1'b0;
    if (fault) begin
      w_state_nxt = ST_ERROR;
    end else if (clear) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = 16'h0000;
      w_presc_nxt = '0;
    end else if (start && (r_state != ST_ERROR)) begin
      if (!bcd_valid(preset)) begin
        w_state_nxt = ST_ERROR;
      end else if (preset == 16'h0000) begin
        w_state_nxt = ST_DONE;
        w_count_nxt = 16'h0000;
        w_presc_nxt = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        w_count_nxt = preset;
        w_presc_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          // Pause beats a pending tick; the prescaler stays put and ticks after resume.
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_count_nxt = w_dec;
            if (w_dec == 16'h0000) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (!pause) w_state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= 16'h0000;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= w_done_nxt;
      r_error   <= (w_state_nxt == ST_ERROR);
    end
  end

  assign running = r_running;
  assign done    = r_done;
  assign error   = r_error;
  assign w_word  = (r_state == ST_ERROR) ? ERR_WORD : r_count;

  display_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock       (clock),
    .reset       (reset),
    .i_word      (w_word),
    .o_data      (data),
    .o_digit_sel (digit_sel)
  );

endmodule
